// File: rtl/snake_dir_ctrl.sv
// PS/2 scan-code parser that feeds filtered direction keys to the snake engine, one per tick.
// Define SNAKE_WASD_EN to let the plain W/A/S/D make codes steer in addition to the E0 arrow keys.
module snake_dir_ctrl #(
   parameter int QDEPTH  = 4,
   parameter int TIMEOUT = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_out,
   input  logic       data_valid,
   output logic       data_ack,
   input  logic       tick,
   output logic [2:0] direction,
   output logic       dir_valid,
   output logic       pause,
   output logic [3:0] q_count
);

   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [3:0] QD = 4'(QDEPTH);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_EXT     = 2'd1;
   localparam logic [1:0] ST_BRK     = 2'd2;
   localparam logic [1:0] ST_EXT_BRK = 2'd3;

   localparam logic [2:0] DIR_NONE  = 3'd0;
   localparam logic [2:0] DIR_UP    = 3'd1;
   localparam logic [2:0] DIR_DOWN  = 3'd2;
   localparam logic [2:0] DIR_LEFT  = 3'd3;
   localparam logic [2:0] DIR_RIGHT = 3'd4;

   logic [2:0]    fifo_mem [QDEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [TW-1:0] timer;

   logic       consume;
   logic       cand_vld;
   logic [2:0] cand;
   logic [2:0] tail;
   logic       toggle;
   logic       accept;
   logic       pop;
   logic       push;

   function automatic logic is_opposite(input logic [2:0] a, input logic [2:0] b);
      return ((a == DIR_UP)    && (b == DIR_DOWN))  ||
             ((a == DIR_DOWN)  && (b == DIR_UP))    ||
             ((a == DIR_LEFT)  && (b == DIR_RIGHT)) ||
             ((a == DIR_RIGHT) && (b == DIR_LEFT));
   endfunction

   function automatic logic [2:0] arrow_code(input logic [7:0] b);
      case (b)
         8'h75:   return DIR_UP;
         8'h72:   return DIR_DOWN;
         8'h6B:   return DIR_LEFT;
         8'h74:   return DIR_RIGHT;
         default: return DIR_NONE;
      endcase
   endfunction

   always_comb begin
      consume   = data_valid & ~data_ack;
      state_nxt = state;
      cand_vld  = 1'b0;
      cand      = DIR_NONE;
      toggle    = 1'b0;

      if (consume) begin
         case (state)
            ST_IDLE: begin
               if (data_out == 8'hE0) begin
                  state_nxt = ST_EXT;
               end else if (data_out == 8'hF0) begin
                  state_nxt = ST_BRK;
               end else if (data_out == 8'h29) begin
                  toggle = 1'b1;
`ifdef SNAKE_WASD_EN
               end else if (data_out == 8'h1D) begin
                  cand_vld = 1'b1;
                  cand     = DIR_UP;
               end else if (data_out == 8'h1B) begin
                  cand_vld = 1'b1;
                  cand     = DIR_DOWN;
               end else if (data_out == 8'h1C) begin
                  cand_vld = 1'b1;
                  cand     = DIR_LEFT;
               end else if (data_out == 8'h23) begin
                  cand_vld = 1'b1;
                  cand     = DIR_RIGHT;
`endif
               end
            end
            ST_EXT: begin
               if (data_out == 8'hF0) begin
                  state_nxt = ST_EXT_BRK;
               end else begin
                  state_nxt = ST_IDLE;
                  cand      = arrow_code(data_out);
                  cand_vld  = (cand != DIR_NONE);
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end else if ((state != ST_IDLE) && (timer == TW'(TIMEOUT - 1))) begin
         state_nxt = ST_IDLE;
      end

      // Filter against the newest pending entry, or the live direction when nothing is queued.
      tail   = (q_count != 4'd0) ? fifo_mem[wr_ptr - PW'(1)] : direction;
      accept = cand_vld &&
               ((tail == DIR_NONE) || ((cand != tail) && !is_opposite(tail, cand)));
      pop    = tick & ~pause & (q_count != 4'd0);
      push   = accept & ((q_count != QD) | pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_ack  <= 1'b0;
         state     <= ST_IDLE;
         timer     <= '0;
         pause     <= 1'b0;
         q_count   <= 4'd0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         direction <= DIR_NONE;
         dir_valid <= 1'b0;
      end else begin
         data_ack  <= consume;
         state     <= state_nxt;
         pause     <= pause ^ toggle;
         dir_valid <= pop;

         if (consume || (state == ST_IDLE) || (state_nxt == ST_IDLE))
            timer <= '0;
         else
            timer <= timer + TW'(1);

         if (pop) begin
            direction <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + PW'(1);
         end
         if (push)
            wr_ptr <= wr_ptr + PW'(1);

         case ({push, pop})
            2'b10:   q_count <= q_count + 4'd1;
            2'b01:   q_count <= q_count - 4'd1;
            default: q_count <= q_count;
         endcase
      end
   end

   // Queue storage holds data only; occupancy and pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= cand;
   end

endmodule

// File: doc/snake_dir_ctrl.md
# snake_dir_ctrl

Scan-code controller between the PS/2 receiver and the snake game engine. It consumes bytes from the receiver over a valid/ack handshake and parses make, break and extended (E0) sequences. Direction keys are filtered against reversal and repeats, buffered in a small FIFO, and released one per game tick. A pause flag toggles on the Space key.

## Interface
- QDEPTH, 4: direction FIFO depth; legal values 2, 4, 8.
- TIMEOUT, 50000: cycles a prefix state (after E0/F0) waits for its next byte before returning to IDLE; minimum 2.

- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- data_out  in  8  scan-code byte from the PS/2 receiver.
- data_valid  in  1  byte available; held by the receiver until acked.
- data_ack  out  1  one-cycle pulse; the byte has been consumed.
- tick  in  1  game-step strobe, one cycle wide.
- direction  out  3  000 none, 001 up, 010 down, 011 left, 100 right.
- dir_valid  out  1  one-cycle pulse; direction was updated from the FIFO.
- pause  out  1  pause flag.
- q_count  out  4  FIFO occupancy, 0..QDEPTH.

## Operation
- Consume rule: a byte is consumed in a cycle where data_valid=1 and data_ack=0. data_ack=1 in the next cycle only. A byte is never consumed twice.
- Parser FSM, one transition per consumed byte:
  - IDLE: E0 -> EXT; F0 -> BRK; 1D/1B/1C/23 -> candidate up/down/left/right (WASD, see Configuration); 29 -> toggle pause; any other byte ignored.
  - EXT: F0 -> EXT_BRK; 75/72/6B/74 -> candidate up/down/left/right, then IDLE; any other byte -> IDLE.
  - BRK, EXT_BRK: any byte -> IDLE. Break codes never enqueue and never toggle pause.
- Timeout: in EXT, BRK or EXT_BRK, a cycle counter runs. When it reaches TIMEOUT with no byte consumed, the FSM returns to IDLE. The counter clears on every consumed byte and on entry to IDLE.
- Candidate filter. The tail is the last enqueued entry if q_count>0, otherwise direction. A candidate is dropped if:
  - it equals the tail (typematic repeat), or
  - it is opposite to the tail (up/down, left/right).
  When the tail is 000, any candidate is accepted.
- FIFO: an accepted candidate is pushed. If q_count=QDEPTH, the new candidate is dropped and the stored entries are kept.
- Pop: on tick with pause=0 and q_count>0, the head goes to direction and dir_valid pulses. A tick while paused, or with an empty FIFO, leaves direction unchanged and dir_valid=0.
- Simultaneous push and pop:
  - both occur and q_count is unchanged;
  - if the FIFO is empty, the pop sees empty, the push lands, and q_count becomes 1;
  - if the FIFO is full, the pop frees a slot and the push is accepted.
- The tail for a filter decision comes from registered state in the consume cycle.
- Pause toggle and tick in the same cycle: the tick is judged by the pre-toggle pause value.

## Timing
- Reset values: direction=000, dir_valid=0, data_ack=0, pause=0, q_count=0, FSM=IDLE, timer=0.
- Reset asserted mid-sequence clears all of the above immediately and empties the FIFO. A pending byte is re-consumed after release.
- Byte consumed in cycle N: data_ack=1 in cycle N+1; q_count and pause reflect the byte in cycle N+1.
- Tick in cycle T that causes a pop: direction and dir_valid=1 in cycle T+1; dir_valid=0 in cycle T+2.
- Throughput: one byte per two cycles at most.

## Configuration
- SNAKE_WASD_EN defined: the non-extended codes 1D, 1B, 1C, 23 in IDLE produce direction candidates.
- SNAKE_WASD_EN undefined: these codes are ignored in IDLE. Only E0-prefixed arrow keys steer. Space and the break handling are unaffected.

## Test plan
- Reset, then bytes E0, 75, then tick -> two data_ack pulses, q_count=1, then direction=001 with dir_valid high for exactly one cycle and q_count=0.
- Bytes E0, F0, 75 -> FSM back in IDLE, q_count=0, direction stays 000.
- direction=001, bytes E0, 72 -> dropped, q_count=0. Then bytes E0, 6B -> q_count=1. Then bytes E0, 6B again -> repeat dropped, q_count=1.
- QDEPTH=4, from 000, push up, left, up, left, up -> q_count=4, fifth dropped. Four ticks -> direction 001, 011, 001, 011.
- Byte E0, then TIMEOUT idle cycles, then byte 75 -> treated in IDLE and ignored, q_count=0.
- Byte 29 -> pause=1; a queued entry stays on tick (q_count unchanged). Bytes F0, 29 -> pause still 1. Byte 29 -> pause=0. With SNAKE_WASD_EN undefined, byte 1D -> q_count=0.
